// File: rtl/btb_pkg.sv
// btb_pkg: shared types, widths and PC field extraction for the BTB update scheduler
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
package btb_pkg;
    localparam int ADDR_W = `ADDR_WIDTH;
    typedef enum logic [1:0] {INIT, RUN, URGENT} sched_state_t;
    function automatic int line_w(input int idx_w);
        return ADDR_W + (ADDR_W - idx_w - 2);
    endfunction
    function automatic logic [ADDR_W-1:0] pc_index(input logic [ADDR_W-1:0] pc, input int idx_w);
        return (pc >> 2) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
    endfunction
    function automatic logic [ADDR_W-1:0] pc_tag(input logic [ADDR_W-1:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction
endpackage

// File: rtl/branch_fb_ifc.sv
// branch_fb_ifc: one resolved-branch feedback slot
interface branch_fb_ifc;
    import btb_pkg::*;
    logic              if_branch;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] new_pc;
    modport in (input if_branch, branch_pc, new_pc);
endinterface

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: 2-push/2-pop circular update FIFO with head-pair index collision flag
module btb_upd_fifo #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 10,
    parameter int LINE_W = 52,
    localparam int UW = IDX_W + LINE_W,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    push,
    input  logic [UW-1:0] din [2],
    input  logic [1:0]    pop_n,
    output logic [UW-1:0] head [2],
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          collide
);
    logic [UW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] room;
    logic          acc0, acc1;
    logic [1:0]    npush;
    always_comb begin
        // slots freed by this cycle's pops are already usable by this cycle's pushes
        room = CW'(DEPTH) - count + CW'(pop_n);
        acc0 = push[0] && room != '0;
        acc1 = push[1] && room > CW'(acc0);
        npush = {1'b0, acc0} + {1'b0, acc1};
        count_next = count + CW'(npush) - CW'(pop_n);
        head[0] = mem[rd_ptr];
        head[1] = mem[rd_ptr + PW'(1)];
        collide = count > CW'(1) && head[0][UW-1 -: IDX_W] == head[1][UW-1 -: IDX_W];
    end
    always_ff @(posedge clk) begin
        if (acc0) mem[wr_ptr] <= din[0];
        if (acc1) mem[wr_ptr + PW'(acc0)] <= din[1];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop_n);
            wr_ptr <= wr_ptr + PW'(npush);
            count <= count_next;
        end
    end
endmodule

// File: rtl/btb_update_scheduler.sv
// btb_update_scheduler: arbitrates fetch reads and buffered branch updates onto the dual-port BTB RAM.
// Define BTB_INIT_CLEAR_EN to sweep the RAM to zero after reset before serving fetch.
module btb_update_scheduler import btb_pkg::*; #(
    parameter int SIZE = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_WAIT = 16,
    localparam int IDX_W = $clog2(SIZE),
    localparam int LINE_W = line_w($clog2(SIZE))
) (
    input  logic              clk,
    input  logic              reset,
    branch_fb_ifc.in          i_fb [2],
    input  logic [ADDR_W-1:0] read_addr [2],
    input  logic [1:0]        valid_read_addr,
    output logic [IDX_W-1:0]  ram_addr [2],
    output logic [1:0]        ram_we,
    output logic [LINE_W-1:0] ram_din [2],
    output logic [1:0]        rd_granted,
    output logic              read_stall,
    output logic              fb_stall,
    output logic              init_done
);
    localparam int UW = IDX_W + LINE_W;
    localparam int TAG_W = LINE_W - ADDR_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = $clog2(MAX_WAIT + 1);
    sched_state_t  state, state_n;
    logic [AW-1:0] age, age_n;
    logic [UW-1:0] enq [2];
    logic [UW-1:0] head [2];
    logic [CW-1:0] count, count_next;
    logic [1:0]    pop_n, free;
    logic          collide;
`ifdef BTB_INIT_CLEAR_EN
    logic [IDX_W-2:0] sweep;
`endif
    function automatic logic [UW-1:0] mk_upd(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] target);
        return {IDX_W'(pc_index(pc, IDX_W)), TAG_W'(pc_tag(pc, IDX_W)), target};
    endfunction
    always_comb begin
        enq[0] = mk_upd(i_fb[0].branch_pc, i_fb[0].new_pc);
        enq[1] = mk_upd(i_fb[1].branch_pc, i_fb[1].new_pc);
    end
    btb_upd_fifo #(.DEPTH(FIFO_DEPTH), .IDX_W(IDX_W), .LINE_W(LINE_W)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push({i_fb[1].if_branch, i_fb[0].if_branch}),
        .din(enq),
        .pop_n(pop_n),
        .head(head),
        .count(count),
        .count_next(count_next),
        .collide(collide)
    );
    always_comb begin
        state_n = state;
        free = state == URGENT ? 2'b11 : ~valid_read_addr;
        pop_n = 2'd0;
        ram_we = 2'b00;
        for (int p = 0; p < 2; p++) begin
            ram_addr[p] = free[p] ? head[0][UW-1 -: IDX_W] : IDX_W'(pc_index(read_addr[p], IDX_W));
            ram_din[p] = free[p] ? head[0][LINE_W-1:0] : '0;
        end
        if (free == 2'b11) begin
            // older head goes to port 0; on an index clash only the younger entry is written
            ram_addr[1] = head[1][UW-1 -: IDX_W];
            ram_din[1] = head[1][LINE_W-1:0];
            pop_n = count > CW'(1) ? 2'd2 : {1'b0, count != '0};
            ram_we = {count > CW'(1), count != '0 && !collide};
        end else if (free != 2'b00) begin
            pop_n = {1'b0, count != '0};
            ram_we = free & {2{count != '0}};
        end
        if (state == RUN && (age == AW'(MAX_WAIT) || count >= CW'(FIFO_DEPTH - 1))) state_n = URGENT;
        if (state == URGENT && count_next <= CW'(FIFO_DEPTH / 2)) state_n = RUN;
`ifdef BTB_INIT_CLEAR_EN
        if (state == INIT) begin
            pop_n = 2'd0;
            ram_we = 2'b11;
            ram_addr[0] = {sweep, 1'b0};
            ram_addr[1] = {sweep, 1'b1};
            ram_din[0] = '0;
            ram_din[1] = '0;
            state_n = &sweep ? RUN : INIT;
        end
`endif
        if (reset) begin
            pop_n = 2'd0;
            ram_we = 2'b00;
        end
        age_n = (count == '0 || pop_n != 2'd0) ? '0 : age == AW'(MAX_WAIT) ? age : age + AW'(1);
        read_stall = reset || state != RUN;
        fb_stall = !reset && (CW'(FIFO_DEPTH) - count) < CW'(2);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef BTB_INIT_CLEAR_EN
            state <= INIT;
            init_done <= 1'b0;
            sweep <= '0;
`else
            state <= RUN;
            init_done <= 1'b1;
`endif
            age <= '0;
            rd_granted <= 2'b00;
        end else begin
            state <= state_n;
            age <= age_n;
            rd_granted <= state == RUN ? valid_read_addr : 2'b00;
`ifdef BTB_INIT_CLEAR_EN
            if (state == INIT) sweep <= sweep + 1'b1;
            if (state == INIT && &sweep) init_done <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_btb_update_scheduler.sv
// tb_btb_update_scheduler: randomized and directed checks against a queue-based scheduler model
module tb_btb_update_scheduler;
    localparam int SIZE = 1024;
    localparam int DEPTH = 8;
    localparam int MAX_WAIT = 16;
    localparam int IDX_W = 10;
    localparam int LW = 2 * 32 - IDX_W - 2;
`ifdef BTB_INIT_CLEAR_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    typedef struct packed {
        logic [31:0] idx;
        logic [63:0] line;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       read_addr [2];
    logic [1:0]        valid_read_addr = 2'b00;
    logic [IDX_W-1:0]  ram_addr [2];
    logic [1:0]        ram_we;
    logic [LW-1:0]     ram_din [2];
    logic [1:0]        rd_granted;
    logic              read_stall, fb_stall, init_done;
    branch_fb_ifc fb [2] ();

    btb_update_scheduler #(.SIZE(SIZE), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk),
        .reset(reset),
        .i_fb(fb),
        .read_addr(read_addr),
        .valid_read_addr(valid_read_addr),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_din(ram_din),
        .rd_granted(rd_granted),
        .read_stall(read_stall),
        .fb_stall(fb_stall),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    ent_t       q[$];
    int         age, m_k, errors, checks;
    bit         urg, m_init, m_done, saw_urg;
    logic [1:0] m_grant;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] np);
        ent_t e;
        e.idx = (pc >> 2) & (SIZE - 1);
        e.line = ({32'd0, pc >> (IDX_W + 2)} << 32) | {32'd0, np};
        return e;
    endfunction

    function automatic bit fb_ok();
        return (DEPTH - q.size()) >= 2;
    endfunction

    task automatic model_reset();
        q.delete();
        age = 0;
        urg = 0;
        m_grant = 2'b00;
        m_init = FEAT;
        m_done = !FEAT;
        m_k = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        valid_read_addr = 2'b00;
        fb[0].if_branch = 1'b0;
        fb[1].if_branch = 1'b0;
        #1;
        check("rst_read_stall", read_stall, 1);
        check("rst_fb_stall", fb_stall, 0);
        check("rst_we", ram_we, 0);
        @(negedge clk);
        model_reset();
    endtask

    task automatic step(input logic [1:0] v, input logic b0, input logic [31:0] p0, input logic [31:0] n0,
                        input logic b1, input logic [31:0] p1, input logic [31:0] n1);
        logic [1:0]  fr, we_e, chk;
        logic [63:0] ad [2];
        logic [63:0] dn [2];
        int          npop, sz;
        bit          urg_c;
        @(negedge clk);
        reset = 1'b0;
        read_addr[0] = $urandom;
        read_addr[1] = $urandom;
        valid_read_addr = v;
        fb[0].if_branch = b0; fb[0].branch_pc = p0; fb[0].new_pc = n0;
        fb[1].if_branch = b1; fb[1].branch_pc = p1; fb[1].new_pc = n1;
        #1;
        sz = q.size();
        check("rd_granted", rd_granted, m_grant);
        check("init_done", init_done, m_done);
        check("fb_stall", fb_stall, (DEPTH - sz) < 2);
        check("read_stall", read_stall, m_init || urg);
        npop = 0;
        we_e = 2'b00;
        chk = 2'b00;
        if (m_init) begin
            we_e = 2'b11;
            chk = 2'b11;
            ad[0] = 2 * m_k;
            ad[1] = 2 * m_k + 1;
            dn[0] = 0;
            dn[1] = 0;
        end else begin
            fr = urg ? 2'b11 : ~v;
            for (int p = 0; p < 2; p++)
                if (!fr[p]) begin
                    chk[p] = 1'b1;
                    ad[p] = (read_addr[p] >> 2) & (SIZE - 1);
                    dn[p] = 0;
                end
            for (int p = 0; p < 2; p++)
                if (fr[p] && npop < sz) begin
                    we_e[p] = 1'b1;
                    chk[p] = 1'b1;
                    ad[p] = q[npop].idx;
                    dn[p] = q[npop].line;
                    npop++;
                end
            if (npop == 2 && q[0].idx == q[1].idx) begin
                we_e[0] = 1'b0;
                chk[0] = 1'b0;
            end
        end
        check("ram_we", ram_we, we_e);
        for (int p = 0; p < 2; p++)
            if (chk[p]) begin
                check(p == 0 ? "ram_addr0" : "ram_addr1", ram_addr[p], ad[p]);
                check(p == 0 ? "ram_din0" : "ram_din1", ram_din[p], dn[p]);
            end
        urg_c = urg;
        m_grant = (!m_init && !urg_c) ? v : 2'b00;
        if (!m_init && !urg_c && (age == MAX_WAIT || sz >= DEPTH - 1)) urg = 1;
        age = (sz == 0 || npop > 0) ? 0 : (age == MAX_WAIT ? age : age + 1);
        repeat (npop) void'(q.pop_front());
        if (b0 && q.size() < DEPTH) q.push_back(mk(p0, n0));
        if (b1 && q.size() < DEPTH) q.push_back(mk(p1, n1));
        if (urg_c && q.size() <= DEPTH / 2) urg = 0;
        if (m_init) begin
            if (m_k == SIZE / 2 - 1) begin
                m_init = 0;
                m_done = 1;
            end else m_k++;
        end
    endtask

    task automatic idle(input logic [1:0] v);
        step(v, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic finish_init();
        while (m_init) idle(2'b00);
    endtask

    function automatic logic [31:0] rpc();
        return ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 12) | $urandom_range(0, 3);
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        read_addr[0] = 0;
        read_addr[1] = 0;
        fb[0].if_branch = 0; fb[0].branch_pc = 0; fb[0].new_pc = 0;
        fb[1].if_branch = 0; fb[1].branch_pc = 0; fb[1].new_pc = 0;
        do_reset();
`ifdef BTB_INIT_CLEAR_EN
        repeat (5) idle(2'b00);
        do_reset();
`endif
        idle(2'b00);
        finish_init();
        repeat (MAX_WAIT + 2) idle(2'b00);
        step(2'b00, 1, 32'h100, 32'h200, 0, 0, 0);
        idle(2'b00);
        check("plan_we0", ram_we[0], 1);
        check("plan_addr0", ram_addr[0], 'h40);
        check("plan_din0", ram_din[0], 'h200);
        step(2'b11, 1, 32'h1000, 32'h11, 1, 32'h2004, 32'h22);
        step(2'b11, 1, 32'h3008, 32'h33, 0, 0, 0);
        saw_urg = 0;
        for (int i = 0; i < 2 * MAX_WAIT + 8; i++) begin
            idle(2'b11);
            if (read_stall) saw_urg = 1;
        end
        check("urgent_seen", saw_urg, 1);
        check("grant_resumed", rd_granted, 2'b11);
        step(2'b00, 1, 32'h300, 32'h111, 1, 32'h1000300, 32'h222);
        idle(2'b00);
        check("collide_we", ram_we, 2'b10);
        check("collide_din1", ram_din[1], ({32'd0, 32'h1000300 >> (IDX_W + 2)} << 32) | 64'h222);
        for (int i = 0; i < 30; i++)
            if (fb_ok()) step(2'b11, 1, rpc(), $urandom, 1, rpc(), $urandom);
            else idle(2'b11);
        for (int i = 0; i < 4; i++) step(2'b11, 1, rpc(), $urandom, 1, rpc(), $urandom);
        do_reset();
        idle(2'b11);
        finish_init();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                idle(2'b00);
            end else if (fb_ok() || $urandom_range(0, 9) == 0)
                step(2'($urandom), 1'($urandom), rpc(), $urandom, 1'($urandom), rpc(), $urandom);
            else idle(2'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
